mmio_display_timer: RTL and testbench
=====================================

// Module: mmio_display_timer
// PURPOSE
//  Memory-mapped responder on the CPU data-memory bus, alongside cache_system. Decodes a 16-byte
//  window at BASE_ADDR holding a display register that drives the seven-segment digits, plus a
//  prescaled 32-bit timer with compare match and interrupt. Accepts byte, half-word and word
//  loads and stores. Accesses outside the window are ignored.
// PARAMETERS
//  BASE_ADDR   32'hFFFF_0000  window base; bits [3:0] must be 0
//  PRESCALE    1000           clk cycles per timer tick, >= 1
//  DISP_INIT   32'h0000_0000  reset value of DISP
// PORTS
//  clk         in   1   system clock (secondary_clk domain)
//  reset       in   1   synchronous, active-high reset
//  addr        in   32  byte address from CPU (MemAddr)
//  data_in     in   32  store data, right-justified (toMem)
//  write_en    in   1   store strobe, one cycle per access
//  read_en     in   1   load strobe, one cycle per access
//  control     in   2   size: 00 byte, 01 half, 10 word, 11 reserved (treated as word)
//  sel         out  1   combinational: addr[31:4] == BASE_ADDR[31:4]
//  data_out    out  32  registered load data, zero-extended, right-justified
//  rd_valid    out  1   high one cycle after an accepted load
//  bus_err     out  1   high one cycle after a selected misaligned access
//  disp_value  out  32  DISP register contents, to display decoders
//  irq         out  1   CTRL.flag & CTRL.irq_en
// BEHAVIOUR
//  Register map (offset addr[3:2]): 0 DISP rw; 1 TIMER rw; 2 CMP rw;
//   3 CTRL: [0] en, [1] auto_reload, [2] irq_en, [3] flag (read; write 1 clears), others read 0.
//  Reset: DISP=DISP_INIT, TIMER=0, CMP=32'hFFFF_FFFF, CTRL=0, prescaler=0, data_out=0,
//   rd_valid=0, bus_err=0.
//  Alignment: byte any addr[1:0]; half needs addr[0]=0; word needs addr[1:0]=0. Misaligned and
//   selected -> no register change, data_out=0, bus_err=1 next cycle; rd_valid pulses if it was a load.
//  Stores (write_en & sel & aligned): update only addressed lanes at the clock edge; byte lane
//   addr[1:0], half lanes addr[1]. Partial writes to CTRL affect only bits in the written lanes.
//  Loads (read_en & sel): data_out <= addressed lane(s) shifted to bit 0, upper bits zero;
//   rd_valid <= 1. Latency exactly 1 cycle; back-to-back loads every cycle supported.
//  read_en & write_en together: write performed, read ignored (no rd_valid).
//  Unselected accesses: no state change; data_out holds, rd_valid=0.
//  Prescaler: counts 0..PRESCALE-1 while en=1, tick when it equals PRESCALE-1 (then wraps to 0).
//   en=0 freezes prescaler and TIMER. PRESCALE=1 -> tick every enabled cycle.
//  Tick: if TIMER==CMP -> flag<=1 and TIMER<=(auto_reload ? 0 : TIMER+1); else TIMER<=TIMER+1
//   (wraps 32'hFFFF_FFFF -> 0, no flag unless CMP matches).
//  Priority, same cycle: CPU store to TIMER beats tick increment; match set beats W1C clear;
//   store to CMP takes effect for ticks in later cycles only. Loads see pre-edge values.
//  Writing CTRL.en 0->1 clears prescaler to 0.
//  Reset asserted mid-access: reset wins; no rd_valid/bus_err pulse follows.
// TESTING
//  Reset then word load @BASE+0 -> data_out=DISP_INIT, rd_valid=1 exactly 1 cycle after read_en.
//  Word store 32'h1234_5678 @+0, byte store 8'hAB @+2, half load @+2 -> 32'h0000_12AB;
//   disp_value=32'h12AB_5678.
//  Half store @+1 and word load @+6 -> bus_err pulse each, DISP/CMP unchanged, load data_out=0.
//  PRESCALE=4, CMP=3, CTRL=32'h7 -> TIMER advances every 4 cycles, flag/irq set on tick at
//   TIMER==3, TIMER->0; store 32'h8 to CTRL clears flag, irq drops next cycle.
//  auto_reload=0, TIMER=32'hFFFF_FFFF, CMP=5 -> next tick TIMER=0, flag stays 0.
//  Store to TIMER on a tick cycle -> stored value kept; reset asserted with read_en -> rd_valid stays 0.

Source files
------------

// File: rtl/mmio_display_timer.sv
// -----------------------------------------------------------------------------
// mmio_display_timer
//   Memory-mapped responder on the CPU data-memory bus. A 16-byte window at
//   BASE_ADDR holds a display register feeding the seven-segment decoders and a
//   prescaled 32-bit timer with compare match and interrupt.
//
//   Register map (offset addr[3:2]):
//     0 DISP  rw
//     1 TIMER rw
//     2 CMP   rw
//     3 CTRL  [0] en, [1] auto_reload, [2] irq_en, [3] flag (write 1 clears)
//
//   Ports:
//     clk        system clock
//     reset      synchronous, active-high reset
//     addr       byte address from CPU
//     data_in    store data, right-justified
//     write_en   store strobe, one cycle per access
//     read_en    load strobe, one cycle per access
//     control    access size: 00 byte, 01 half, 10 word, 11 word
//     sel        combinational window decode
//     data_out   registered load data, zero-extended, right-justified
//     rd_valid   one-cycle pulse after an accepted load
//     bus_err    one-cycle pulse after a selected misaligned access
//     disp_value DISP register contents
//     irq        CTRL.flag & CTRL.irq_en
// -----------------------------------------------------------------------------
module mmio_display_timer #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int unsigned PRESCALE  = 1000,
    parameter logic [31:0] DISP_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    input  logic        write_en,
    input  logic        read_en,
    input  logic [1:0]  control,
    output logic        sel,
    output logic [31:0] data_out,
    output logic        rd_valid,
    output logic        bus_err,
    output logic [31:0] disp_value,
    output logic        irq
);

    localparam int unsigned   PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PS_ONE  = PW'(1);

    // Replace only the bytes selected by mask with the replicated store data.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [31:0] mask);
        lane_merge = (old_val & ~mask) | (new_val & mask);
    endfunction

    logic [31:0]   r_disp;
    logic [31:0]   r_timer;
    logic [31:0]   r_cmp;
    logic          r_en;
    logic          r_auto;
    logic          r_irq_en;
    logic          r_flag;
    logic [PW-1:0] r_presc;
    logic [31:0]   r_data_out;
    logic          r_rd_valid;
    logic          r_bus_err;

    logic          w_sel;
    logic          w_aligned;
    logic [3:0]    w_lanes;
    logic [31:0]   w_wdata;
    logic [31:0]   w_wmask;
    logic [31:0]   w_rreg;
    logic [31:0]   w_shifted;
    logic [31:0]   w_rdata;
    logic          w_store;
    logic          w_load;
    logic          w_misal;
    logic          w_wr_disp;
    logic          w_wr_timer;
    logic          w_wr_cmp;
    logic          w_wr_ctrl;
    logic          w_tick;
    logic          w_hit;

    assign w_sel = (addr[31:4] == BASE_ADDR[31:4]);

    // Register selected by the word offset, as seen before the clock edge.
    always_comb begin
        w_rreg = 32'h0000_0000;
        case (addr[3:2])
            2'b00:   w_rreg = r_disp;
            2'b01:   w_rreg = r_timer;
            2'b10:   w_rreg = r_cmp;
            default: w_rreg = {28'h000_0000, r_flag, r_irq_en, r_auto, r_en};
        endcase
    end

    // Shifting by the byte offset serves both byte and half loads, because an
    // aligned half always has addr[0]=0.
    assign w_shifted = w_rreg >> {addr[1:0], 3'b000};

    // Size decode: alignment, byte lanes, lane-replicated store data, load data.
    always_comb begin
        w_aligned = 1'b1;
        w_lanes   = 4'b1111;
        w_wdata   = data_in;
        w_rdata   = w_rreg;
        case (control)
            2'b00: begin
                w_aligned = 1'b1;
                w_lanes   = 4'b0001 << addr[1:0];
                w_wdata   = {4{data_in[7:0]}};
                w_rdata   = {24'h00_0000, w_shifted[7:0]};
            end
            2'b01: begin
                w_aligned = ~addr[0];
                w_lanes   = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata   = {2{data_in[15:0]}};
                w_rdata   = {16'h0000, w_shifted[15:0]};
            end
            default: begin
                w_aligned = (addr[1:0] == 2'b00);
                w_lanes   = 4'b1111;
                w_wdata   = data_in;
                w_rdata   = w_rreg;
            end
        endcase
    end

    assign w_wmask = {{8{w_lanes[3]}}, {8{w_lanes[2]}}, {8{w_lanes[1]}}, {8{w_lanes[0]}}};

    assign w_store    = write_en & w_sel & w_aligned;
    assign w_load     = read_en & ~write_en & w_sel & w_aligned;
    assign w_misal    = (read_en | write_en) & w_sel & ~w_aligned;
    assign w_wr_disp  = w_store & (addr[3:2] == 2'b00);
    assign w_wr_timer = w_store & (addr[3:2] == 2'b01);
    assign w_wr_cmp   = w_store & (addr[3:2] == 2'b10);
    // All CTRL bits live in byte lane 0.
    assign w_wr_ctrl  = w_store & (addr[3:2] == 2'b11) & w_lanes[0];

    assign w_tick = r_en & (r_presc == PS_LAST);
    assign w_hit  = w_tick & (r_timer == r_cmp);

    // Register file, timer, prescaler and bus response.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_disp     <= DISP_INIT;
            r_timer    <= 32'h0000_0000;
            r_cmp      <= 32'hFFFF_FFFF;
            r_en       <= 1'b0;
            r_auto     <= 1'b0;
            r_irq_en   <= 1'b0;
            r_flag     <= 1'b0;
            r_presc    <= '0;
            r_data_out <= 32'h0000_0000;
            r_rd_valid <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            if (w_wr_disp) begin
                r_disp <= lane_merge(r_disp, w_wdata, w_wmask);
            end
            if (w_wr_cmp) begin
                r_cmp <= lane_merge(r_cmp, w_wdata, w_wmask);
            end

            // A CPU store to TIMER overrides the tick update in the same cycle.
            if (w_wr_timer) begin
                r_timer <= lane_merge(r_timer, w_wdata, w_wmask);
            end else if (w_tick) begin
                r_timer <= (w_hit & r_auto) ? 32'h0000_0000 : r_timer + 32'd1;
            end

            // A match in the same cycle wins over a write-1-to-clear.
            if (w_hit) begin
                r_flag <= 1'b1;
            end else if (w_wr_ctrl & w_wdata[3]) begin
                r_flag <= 1'b0;
            end

            if (w_wr_ctrl) begin
                r_en     <= w_wdata[0];
                r_auto   <= w_wdata[1];
                r_irq_en <= w_wdata[2];
            end

            // Enabling restarts the prescale period from zero.
            if (w_wr_ctrl & w_wdata[0] & ~r_en) begin
                r_presc <= '0;
            end else if (r_en) begin
                r_presc <= (r_presc == PS_LAST) ? '0 : r_presc + PS_ONE;
            end

            if (w_load) begin
                r_data_out <= w_rdata;
            end else if (w_misal) begin
                r_data_out <= 32'h0000_0000;
            end

            r_rd_valid <= read_en & ~write_en & w_sel;
            r_bus_err  <= w_misal;
        end
    end

    assign sel        = w_sel;
    assign data_out   = r_data_out;
    assign rd_valid   = r_rd_valid;
    assign bus_err    = r_bus_err;
    assign disp_value = r_disp;
    assign irq        = r_flag & r_irq_en;

endmodule

// File: tb/tb_mmio_display_timer.sv
// -----------------------------------------------------------------------------
// tb_mmio_display_timer
//   Directed bench for mmio_display_timer (PRESCALE=4). A byte-oriented
//   reference model tracks the register window and timer; every falling edge
//   the DUT outputs are compared against it. Directed steps also check
//   hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_mmio_display_timer;

    localparam int          P     = 4;
    localparam logic [31:0] BASE  = 32'hFFFF_0000;
    localparam logic [31:0] DINIT = 32'h5A5A_0F0F;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic        write_en;
    logic        read_en;
    logic [1:0]  control;
    logic        sel;
    logic [31:0] data_out;
    logic        rd_valid;
    logic        bus_err;
    logic [31:0] disp_value;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    mmio_display_timer #(
        .BASE_ADDR (BASE),
        .PRESCALE  (P),
        .DISP_INIT (DINIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .data_in    (data_in),
        .write_en   (write_en),
        .read_en    (read_en),
        .control    (control),
        .sel        (sel),
        .data_out   (data_out),
        .rd_valid   (rd_valid),
        .bus_err    (bus_err),
        .disp_value (disp_value),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_disp, m_timer, m_cmp, m_dout;
    logic        m_en, m_auto, m_ie, m_flag, m_rv, m_berr;
    logic        m_live = 1'b0;
    int          m_presc;

    function automatic logic [31:0] m_reg(input int idx);
        case (idx)
            0:       m_reg = m_disp;
            1:       m_reg = m_timer;
            2:       m_reg = m_cmp;
            default: m_reg = {28'h0, m_flag, m_ie, m_auto, m_en};
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        logic        tick, hit, ne, na, ni, nf;
        logic [31:0] nd, nt, nc, rw, dout;
        logic [7:0]  v;
        int          np, nb, off, idx, pos;
        if (reset) begin
            m_disp = DINIT; m_timer = 32'h0; m_cmp = 32'hFFFF_FFFF;
            m_en = 1'b0; m_auto = 1'b0; m_ie = 1'b0; m_flag = 1'b0;
            m_presc = 0; m_dout = 32'h0; m_rv = 1'b0; m_berr = 1'b0;
            m_live = 1'b1;
            return;
        end
        tick = m_en && (m_presc == P - 1);
        hit  = tick && (m_timer == m_cmp);
        np   = m_en ? (m_presc + 1) % P : m_presc;
        nt   = tick ? ((hit && m_auto) ? 32'h0 : m_timer + 32'd1) : m_timer;
        nf   = m_flag | hit;
        nd = m_disp; nc = m_cmp; ne = m_en; na = m_auto; ni = m_ie;
        m_rv = 1'b0; m_berr = 1'b0;
        if ((addr[31:4] == BASE[31:4]) && (read_en || write_en)) begin
            nb  = (control == 2'b00) ? 1 : (control == 2'b01) ? 2 : 4;
            off = int'(addr[1:0]);
            idx = int'(addr[3:2]);
            if ((off % nb) != 0) begin
                m_berr = 1'b1;
                m_dout = 32'h0;
                m_rv   = read_en && !write_en;
            end else if (write_en) begin
                for (int k = 0; k < nb; k++) begin
                    v   = data_in[8*k +: 8];
                    pos = off + k;
                    case (idx)
                        0: nd[8*pos +: 8] = v;
                        1: nt[8*pos +: 8] = v;
                        2: nc[8*pos +: 8] = v;
                        default: if (pos == 0) begin
                            ne = v[0]; na = v[1]; ni = v[2];
                            if (v[3] && !hit) nf = 1'b0;
                            if (v[0] && !m_en) np = 0;
                        end
                    endcase
                end
            end else begin
                rw   = m_reg(idx);
                dout = 32'h0;
                for (int k = 0; k < nb; k++) dout[8*k +: 8] = rw[8*(off+k) +: 8];
                m_dout = dout;
                m_rv   = 1'b1;
            end
        end
        m_disp = nd; m_timer = nt; m_cmp = nc; m_en = ne; m_auto = na; m_ie = ni;
        m_flag = nf; m_presc = np;
    endtask

    // Compare on every falling edge, then step the model for the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                check("cyc data_out", data_out, m_dout);
                check("cyc rd_valid", {31'h0, rd_valid}, {31'h0, m_rv});
                check("cyc bus_err", {31'h0, bus_err}, {31'h0, m_berr});
                check("cyc disp_value", disp_value, m_disp);
                check("cyc irq", {31'h0, irq}, {31'h0, m_flag & m_ie});
                check("cyc sel", {31'h0, sel}, {31'h0, addr[31:4] == BASE[31:4]});
            end
            model_step();
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic acc(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
        addr = a; data_in = d; control = sz; read_en = rd; write_en = wr;
        cyc();
        read_en = 1'b0; write_en = 1'b0;
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] off, input logic [31:0] d);
        acc(1'b0, 1'b1, sz, BASE + off, d);
    endtask

    task automatic ld(input logic [1:0] sz, input logic [31:0] off);
        acc(1'b1, 1'b0, sz, BASE + off, 32'h0);
    endtask

    initial begin
        reset = 1'b1; addr = 32'h0; data_in = 32'h0;
        write_en = 1'b0; read_en = 1'b0; control = 2'b10;
        repeat (3) cyc();
        reset = 1'b0;
        check("reset data_out", data_out, 32'h0);
        check("reset rd_valid", {31'h0, rd_valid}, 32'h0);
        check("reset bus_err", {31'h0, bus_err}, 32'h0);
        check("reset disp", disp_value, DINIT);
        check("reset irq", {31'h0, irq}, 32'h0);

        ld(2'b10, 32'h0);
        check("init load data", data_out, DINIT);
        check("init load valid", {31'h0, rd_valid}, 32'h1);
        cyc();
        check("valid one cycle", {31'h0, rd_valid}, 32'h0);

        st(2'b10, 32'h0, 32'h1234_5678);
        st(2'b00, 32'h2, 32'h0000_00AB);
        ld(2'b01, 32'h2);
        check("half load", data_out, 32'h0000_12AB);
        check("disp merged", disp_value, 32'h12AB_5678);
        ld(2'b00, 32'h3);
        check("byte load", data_out, 32'h0000_0012);

        st(2'b01, 32'h1, 32'h0000_BEEF);
        check("mis store err", {31'h0, bus_err}, 32'h1);
        check("mis store valid", {31'h0, rd_valid}, 32'h0);
        check("mis store disp", disp_value, 32'h12AB_5678);
        ld(2'b10, 32'h6);
        check("mis load err", {31'h0, bus_err}, 32'h1);
        check("mis load valid", {31'h0, rd_valid}, 32'h1);
        check("mis load data", data_out, 32'h0);
        ld(2'b10, 32'h8);
        check("cmp unchanged", data_out, 32'hFFFF_FFFF);
        ld(2'b11, 32'h0);
        check("reserved size word", data_out, 32'h12AB_5678);

        acc(1'b1, 1'b0, 2'b10, 32'hFFFF_0010, 32'h0);
        check("unsel valid", {31'h0, rd_valid}, 32'h0);
        check("unsel hold", data_out, 32'h12AB_5678);
        check("unsel sel", {31'h0, sel}, 32'h0);
        acc(1'b0, 1'b1, 2'b10, 32'h0000_0000, 32'hDEAD_0000);
        check("unsel store", disp_value, 32'h12AB_5678);

        acc(1'b1, 1'b1, 2'b10, BASE, 32'hCAFE_F00D);
        check("rw valid", {31'h0, rd_valid}, 32'h0);
        check("rw disp", disp_value, 32'hCAFE_F00D);

        addr = BASE; control = 2'b10; read_en = 1'b1;
        cyc();
        check("b2b first", data_out, 32'hCAFE_F00D);
        addr = BASE + 32'h8;
        cyc();
        check("b2b second", data_out, 32'hFFFF_FFFF);
        check("b2b valid", {31'h0, rd_valid}, 32'h1);
        read_en = 1'b0;

        // Timer with auto-reload: ticks every 4 cycles, match at TIMER==3.
        st(2'b10, 32'h8, 32'h3);
        st(2'b10, 32'hC, 32'h7);
        repeat (15) cyc();
        check("irq before match", {31'h0, irq}, 32'h0);
        cyc();
        check("irq on match", {31'h0, irq}, 32'h1);
        ld(2'b10, 32'h4);
        check("timer reloaded", data_out, 32'h0);
        ld(2'b10, 32'hC);
        check("ctrl read", data_out, 32'h0000_000F);
        st(2'b10, 32'hC, 32'h8);
        check("irq cleared", {31'h0, irq}, 32'h0);

        // Wrap without match, no auto-reload.
        st(2'b10, 32'h8, 32'h5);
        st(2'b10, 32'h4, 32'hFFFF_FFFF);
        st(2'b10, 32'hC, 32'h5);
        repeat (4) cyc();
        ld(2'b10, 32'h4);
        check("timer wrap", data_out, 32'h0);
        check("wrap no irq", {31'h0, irq}, 32'h0);

        // Store on a tick cycle keeps the stored value.
        cyc(); cyc();
        st(2'b10, 32'h4, 32'h0000_0100);
        ld(2'b10, 32'h4);
        check("store beats tick", data_out, 32'h0000_0100);

        st(2'b00, 32'hD, 32'h0000_0000);
        ld(2'b10, 32'hC);
        check("ctrl lane1 write", data_out, 32'h0000_0005);
        st(2'b01, 32'h6, 32'h0000_ABCD);
        repeat (6) cyc();
        ld(2'b01, 32'h6);
        check("timer upper half", data_out, 32'h0000_ABCD);

        addr = BASE; control = 2'b10; read_en = 1'b1; reset = 1'b1;
        cyc();
        check("reset+read valid", {31'h0, rd_valid}, 32'h0);
        check("reset+read data", data_out, 32'h0);
        check("reset+read disp", disp_value, DINIT);
        read_en = 1'b0; reset = 1'b0;
        cyc();
        check("after reset valid", {31'h0, rd_valid}, 32'h0);
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
